// File: rtl/pwm_generator.sv
// 16-channel PWM generator: one shared prescaler/counter/duty shadow drives
// every PWM-mode channel; each output bit is forced low, forced high, or follows PWM.
module pwm_generator #(
   parameter int CLK_DIV = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);

   localparam logic [11:0] PRESC_MAX = 12'(CLK_DIV - 1);
   localparam logic [7:0]  CNT_MAX   = 8'd254;

   logic [11:0] prescaler;
   logic [7:0]  counter;
   logic [7:0]  shadow;
   logic        step;
   logic        load;
   logic        pwm_level;
   logic [15:0] en_out;
   logic [15:0] en_pwm;
   logic [15:0] out_next;

   assign step = (prescaler == PRESC_MAX);
   assign load = (prescaler == 12'd0) && (counter == 8'd0);

   // Full-scale duty stays high even though the counter never reaches 255.
   assign pwm_level = (shadow == 8'hFF) || (counter < shadow);

   assign en_out   = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
   assign out_next = en_out & (~en_pwm | {16{pwm_level}});

   // period_start is registered, so it is high in the first cycle that sees
   // the newly loaded shadow; out follows that shadow one clk later.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prescaler    <= 12'd0;
         counter      <= 8'd0;
         shadow       <= 8'd0;
         out          <= 16'h0000;
         period_start <= 1'b0;
      end else begin
         prescaler <= step ? 12'd0 : prescaler + 12'd1;
         if (step) begin
            counter <= (counter == CNT_MAX) ? 8'd0 : counter + 8'd1;
         end
         if (load) begin
            shadow <= pwm_duty_cycle;
         end
         period_start <= load;
         out          <= out_next;
      end
   end

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: per-period high-time/length scoreboard plus
// directed checks for reset behaviour and static-mode enable latency.
module tb_pwm_generator;

   localparam int PERIOD = 3060;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
   logic [15:0] out;
   logic        period_start;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic             chk;
      logic [11:0]      len;
      logic [15:0][11:0] hi;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   pwm_generator #(.CLK_DIV(12)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .en_reg_out_7_0  (eo_lo),
      .en_reg_out_15_8 (eo_hi),
      .en_reg_pwm_7_0  (ep_lo),
      .en_reg_pwm_15_8 (ep_hi),
      .pwm_duty_cycle  (duty),
      .out             (out),
      .period_start    (period_start)
   );

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
      {eo_hi, eo_lo} = eo;
      {ep_hi, ep_lo} = ep;
   endtask

   // hi_pwm is the hand-computed high time of a PWM-mode channel for the window.
   task automatic push_exp(input logic chk, input logic [15:0] eo, input logic [15:0] ep,
                           input int hi_pwm);
      exp_t x;
      x.chk = chk;
      x.len = 12'(PERIOD);
      for (int b = 0; b < 16; b++) begin
         if (!eo[b])      x.hi[b] = 12'd0;
         else if (!ep[b]) x.hi[b] = 12'(PERIOD);
         else             x.hi[b] = 12'(hi_pwm);
      end
      exp_q.push_back(x);
   endtask

   task automatic wait_ps();
      int cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!period_start && cnt < 4000);
      if (!period_start) check("period_start_timeout", 0, 1);
   endtask

   // Window: cycle after one period_start through the next period_start inclusive.
   bit   win = 1'b0;
   int   win_len;
   int   win_hi[16];
   exp_t e;

   always @(negedge clk) begin
      if (!rst_n) begin
         win = 1'b0;
      end else begin
         if (win) begin
            win_len++;
            for (int b = 0; b < 16; b++) win_hi[b] += int'(out[b]);
         end
         if (period_start) begin
            if (win) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_period", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  if (e.chk) begin
                     check("period_len", win_len, int'(e.len));
                     for (int b = 0; b < 16; b++)
                        check($sformatf("high_time[%0d]", b), win_hi[b], int'(e.hi[b]));
                  end
               end
            end
            win_len = 0;
            foreach (win_hi[b]) win_hi[b] = 0;
            win = 1'b1;
         end
      end
   end

   logic prev;
   logic [7:0] tog_vec [6];

   initial begin
      tog_vec = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1};
      rst_n = 1'b0;
      duty  = 8'd128;
      set_en(16'hFFFF, 16'hFFFF);
      repeat (3) @(negedge clk);
      check("reset_out", int'(out), 0);
      check("reset_period_start", int'(period_start), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ps_after_release", int'(period_start), 1);
      push_exp(1'b1, 16'hFFFF, 16'hFFFF, 1536);

      wait_ps();
      push_exp(1'b1, 16'hFFFF, 16'hFFFF, 1536);
      duty = 8'd0;
      wait_ps();
      push_exp(1'b1, 16'hFFFF, 16'hFFFF, 0);
      wait_ps();
      push_exp(1'b1, 16'hFFFF, 16'hFFFF, 0);
      duty = 8'd255;
      wait_ps();
      push_exp(1'b1, 16'hFFFF, 16'hFFFF, 3060);

      wait_ps();
      set_en(16'h00FF, 16'h000F);
      duty = 8'd64;
      push_exp(1'b1, 16'h00FF, 16'h000F, 3060);
      wait_ps();
      push_exp(1'b1, 16'h00FF, 16'h000F, 768);

      wait_ps();
      set_en(16'hFFFF, 16'hFFFF);
      duty = 8'd10;
      push_exp(1'b1, 16'hFFFF, 16'hFFFF, 768);
      wait_ps();
      push_exp(1'b1, 16'hFFFF, 16'hFFFF, 120);
      repeat (1530) @(negedge clk);
      duty = 8'd200;
      wait_ps();
      push_exp(1'b1, 16'hFFFF, 16'hFFFF, 2400);

      wait_ps();
      set_en(16'hFFFF, 16'hFFFE);
      push_exp(1'b0, 16'hFFFF, 16'hFFFE, 2400);
      @(negedge clk);
      prev = 1'b1;
      for (int i = 0; i < 6; i++) begin
         eo_lo[0] = tog_vec[i][0];
         #1;
         check($sformatf("en_toggle_hold[%0d]", i), int'(out[0]), int'(prev));
         @(negedge clk);
         check($sformatf("en_toggle_follow[%0d]", i), int'(out[0]), int'(tog_vec[i][0]));
         prev = tog_vec[i][0];
      end
      set_en(16'hFFFF, 16'hFFFF);
      repeat (1190) @(negedge clk);

      exp_q.delete();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("mid_reset_out[%0d]", i), int'(out), 0);
         check($sformatf("mid_reset_ps[%0d]", i), int'(period_start), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("ps_after_mid_reset", int'(period_start), 1);
      push_exp(1'b1, 16'hFFFF, 16'hFFFF, 2400);
      wait_ps();
      repeat (2) @(negedge clk);
      check("exp_q_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
